// File: rtl/mcu_arb_pkg.sv
// Shared types and widths for the random-access port arbiter.
package mcu_arb_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;

    // 7.8 us between refreshes at 100 MHz
    localparam int unsigned REFRESH_INTERVAL_DEFAULT = 780;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // One client's command as presented to the controller's random port
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              we;
        logic [BE_W-1:0]   we_array;
        logic [DATA_W-1:0] datain;
    } rand_cmd_t;

endpackage

// File: rtl/refresh_timer.sv
// Free-running down-counter that emits a one-cycle refresh pulse every
// REFRESH_INTERVAL cycles, independent of any arbitration activity.
module refresh_timer
    import mcu_arb_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    output logic refresh_strobe
);

    localparam int unsigned CNT_W = $clog2(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count down, pulse on the zero cycle and reload
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q          <= RELOAD;
            refresh_strobe <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q          <= RELOAD;
            refresh_strobe <= 1'b1;
        end else begin
            cnt_q          <= cnt_q - CNT_W'(1);
            refresh_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/rand_port_arbiter.sv
// Round-robin arbiter sharing one controller random-access port among
// NUM_REQ clients. Each grant runs IDLE -> ISSUE (until ack) -> RELEASE.
// The command fields stay muxed from the last granted client so write data
// remains valid after the acknowledge.
// Build option: define RAND_ARB_REFRESH_TIMER_EN to build the internal
// refresh timer; otherwise refresh_strobe is tied low and refresh comes
// from an external source.
module rand_port_arbiter
    import mcu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          cl_req,
    output logic [NUM_REQ-1:0]          cl_ack,
    input  logic [NUM_REQ*ADDR_W-1:0]   cl_address,
    input  logic [NUM_REQ-1:0]          cl_we,
    input  logic [NUM_REQ*BE_W-1:0]     cl_we_array,
    input  logic [NUM_REQ*DATA_W-1:0]   cl_datain,
    output logic [ADDR_W-1:0]           rand_req_address,
    output logic                        rand_req_we,
    output logic [BE_W-1:0]             rand_req_we_array,
    output logic [DATA_W-1:0]           rand_req_datain,
    output logic                        rand_req,
    input  logic                        rand_req_ack,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic                        refresh_strobe
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Elaboration-time parameter sanity checks
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("rand_port_arbiter: NUM_REQ must be in 2..8");
    end
    if (REFRESH_INTERVAL < 2) begin : g_bad_interval
        $error("rand_port_arbiter: REFRESH_INTERVAL must be at least 2");
    end

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   grant_d;
    logic               rand_req_d;
    logic [NUM_REQ-1:0] cl_ack_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    rand_cmd_t          cmd_sel;

    // First requester at or above ptr, wrapping past the last client
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_valid && cl_req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_idx;
        rand_req_d = 1'b0;
        cl_ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    rand_req_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Requests are not re-sampled here: a client that drops
                // cl_req mid-transaction still gets its access completed.
                if (rand_req_ack) begin
                    cl_ack_d = NUM_REQ'(1) << grant_idx;
                    ptr_d    = (grant_idx == LAST_IDX) ? '0
                                                       : grant_idx + IDX_W'(1);
                    state_d  = RELEASE;
                end else begin
                    rand_req_d = 1'b1;
                end
            end
            RELEASE: begin
                // One dead cycle lets the acked client lower cl_req
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_idx <= '0;
            rand_req  <= 1'b0;
            cl_ack    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_idx <= grant_d;
            rand_req  <= rand_req_d;
            cl_ack    <= cl_ack_d;
        end
    end

    // Command mux steered by the registered grant, held until the next grant
    always_comb begin
        cmd_sel          = '0;
        cmd_sel.address  = cl_address[grant_idx*ADDR_W +: ADDR_W];
        cmd_sel.we       = cl_we[grant_idx];
        cmd_sel.we_array = cl_we_array[grant_idx*BE_W +: BE_W];
        cmd_sel.datain   = cl_datain[grant_idx*DATA_W +: DATA_W];
    end

    assign rand_req_address  = cmd_sel.address;
    assign rand_req_we       = cmd_sel.we;
    assign rand_req_we_array = cmd_sel.we_array;
    assign rand_req_datain   = cmd_sel.datain;

`ifdef RAND_ARB_REFRESH_TIMER_EN
    refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .CLK            (CLK),
        .RST            (RST),
        .refresh_strobe (refresh_strobe)
    );
`else
    assign refresh_strobe = 1'b0;
`endif

endmodule

// File: doc/rand_port_arbiter.md
RAND_PORT_ARBITER -- requirements
Module: rand_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of random-access requesters (2..8).
REQ-002 SHALL have parameter REFRESH_INTERVAL, 780, cycles between refresh strobes (7.8 us at 100 MHz).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cl_req  input  NUM_REQ  per-client request, held high until ack.
REQ-006 SHALL have port cl_ack  output  NUM_REQ  per-client one-cycle acceptance pulse.
REQ-007 SHALL have port cl_address  input  NUM_REQ*26  per-client word address.
REQ-008 SHALL have port cl_we  input  NUM_REQ  per-client write enable.
REQ-009 SHALL have port cl_we_array  input  NUM_REQ*4  per-client byte enables.
REQ-010 SHALL have port cl_datain  input  NUM_REQ*32  per-client write data.
REQ-011 SHALL have port rand_req_address, rand_req_we, rand_req_we_array, rand_req_datain  output  26/1/4/32  muxed fields to the controller's random port.
REQ-012 SHALL have port rand_req  output  1  request to the controller.
REQ-013 SHALL have port rand_req_ack  input  1  controller acceptance, one-cycle pulse.
REQ-014 SHALL have port grant_idx  output  clog2(NUM_REQ)  index of current/last granted client.
REQ-015 SHALL have port refresh_strobe  output  1  one-cycle refresh pulse to the controller.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RELEASE.
REQ-017 IDLE: when any cl_req is high, SHALL select the first requesting client searching upward (wrapping) from pointer ptr, register grant_idx, and enter ISSUE next cycle with rand_req=1.
REQ-018 ISSUE: rand_req SHALL stay 1 until the cycle rand_req_ack=1; in the following cycle rand_req=0, cl_ack[grant_idx]=1 for exactly one cycle, ptr=grant_idx+1 mod NUM_REQ, state=RELEASE.
REQ-019 RELEASE SHALL last exactly one cycle, ignore all cl_req, and return to IDLE, giving the client one cycle to drop cl_req.
REQ-020 rand_req_address/we/we_array/datain SHALL be a combinational mux of client fields selected by registered grant_idx, held on the last grant until the next grant, so write data stays valid after ack.
REQ-021 A client dropping cl_req while in ISSUE SHALL NOT abort the transaction; the request completes and is acked.
REQ-022 rand_req_ack received outside ISSUE SHALL be ignored.
REQ-023 Minimum spacing between two grants SHALL be 4 cycles (IDLE, ISSUE, ack cycle, RELEASE); all-clients-requesting SHALL yield strict round-robin order.
REQ-024 Refresh counter SHALL count down from REFRESH_INTERVAL-1, pulse refresh_strobe for one cycle at zero, reload, and run independently of the FSM.

Reset
REQ-025 On RST=1 at a clock edge: state=IDLE, ptr=0, grant_idx=0, rand_req=0, cl_ack=0, refresh_strobe=0, refresh counter=REFRESH_INTERVAL-1.
REQ-026 Reset mid-ISSUE SHALL drop rand_req the next cycle without issuing cl_ack; the client retries.

Configuration
REQ-027 With macro RAND_ARB_REFRESH_TIMER_EN defined, REQ-024 SHALL apply; undefined, refresh_strobe SHALL be constant 0, no counter SHALL be built, and an external refresh source is used.

Structure
REQ-028 Package mcu_arb_pkg SHALL hold the FSM state enum, field widths (26, 4, 32) and the REFRESH_INTERVAL default.
REQ-029 Refresh counter SHALL be sub-module refresh_timer (CLK, RST, refresh_strobe), instantiated only under RAND_ARB_REFRESH_TIMER_EN.

Verification
REQ-030 cl_req=4'b0100 only; controller acks 3 cycles after rand_req -> grant_idx=2, rand_req high 3 cycles, cl_ack=4'b0100 for one cycle, address equals client 2's.
REQ-031 cl_req=4'b1111 held, ack after 1 cycle each -> grant order 0,1,2,3,0; no client granted twice in a row.
REQ-032 ptr=3, cl_req=4'b1001 -> client 3 granted first, then client 0.
REQ-033 RST pulsed while rand_req=1 -> rand_req=0 next cycle, no cl_ack, state IDLE, ptr=0.
REQ-034 REFRESH_INTERVAL=10, macro defined -> refresh_strobe pulses at cycles 10, 20, 30 after reset release; macro undefined -> never pulses.
REQ-035 Spurious rand_req_ack in IDLE -> no cl_ack, no state change.
